// File: rtl/mfp_ahb_sdram_bridge.sv
// AHB-Lite slave front end for the SDRAM controller: turns single transfers into command,
// write-data and read-data FIFO traffic. Define MFP_AHB_SDRAM_ALIGN_ERR_EN to reject misaligned transfers.
module mfp_ahb_sdram_bridge #(
  parameter int unsigned ADDR_WIDTH = 26
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        CFIFO_WEN,
  output logic [35:0] CFIFO_WDATA,
  input  logic        CFIFO_WFULL,
  output logic        WFIFO_WEN,
  output logic [32:0] WFIFO_WDATA,
  input  logic        WFIFO_WFULL,
  output logic        RFIFO_REN,
  input  logic [32:0] RFIFO_RDATA,
  input  logic        RFIFO_REMPTY
);

  localparam logic [31:0] AddrMask = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                     ((32'd1 << ADDR_WIDTH) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RCMD, S_RWAIT, S_RDATA, S_ERR1, S_ERR2
  } state_e;

  state_e      r_state, w_state_nxt, w_after_xfer;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_write;
  logic [31:0] r_hrdata;

  logic w_capture, w_wroom, w_misalign;
  logic w_unused_bits;

  assign w_capture     = HSEL & HTRANS[1] & HREADY;
  assign w_wroom       = ~(CFIFO_WFULL | WFIFO_WFULL);
  assign w_unused_bits = ^{HTRANS[0], RFIFO_RDATA[32]};

`ifdef MFP_AHB_SDRAM_ALIGN_ERR_EN
  assign w_misalign = (HSIZE > 3'b010) |
                      ((HSIZE == 3'b001) & HADDR[0]) |
                      ((HSIZE == 3'b010) & (|HADDR[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  // Where a final data-phase cycle goes: a new transfer if one is being captured, else idle.
  always_comb begin
    w_after_xfer = S_IDLE;
    if (w_capture) begin
      if (w_misalign)  w_after_xfer = S_ERR1;
      else if (HWRITE) w_after_xfer = S_WDATA;
      else             w_after_xfer = S_RCMD;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = w_after_xfer;
      S_WDATA: if (w_wroom) w_state_nxt = w_after_xfer;
      S_RCMD:  if (!CFIFO_WFULL) w_state_nxt = S_RWAIT;
      S_RWAIT: if (!RFIFO_REMPTY) w_state_nxt = S_RDATA;
      S_RDATA: w_state_nxt = w_after_xfer;
      S_ERR1:  w_state_nxt = S_ERR2;
      S_ERR2:  w_state_nxt = w_after_xfer;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    CFIFO_WEN = 1'b0;
    WFIFO_WEN = 1'b0;
    RFIFO_REN = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_WDATA: begin
        // Both pushes share one qualifier so the two FIFOs never get out of step.
        HREADYOUT = w_wroom;
        CFIFO_WEN = w_wroom;
        WFIFO_WEN = w_wroom;
      end
      S_RCMD: begin
        HREADYOUT = 1'b0;
        CFIFO_WEN = ~CFIFO_WFULL;
      end
      S_RWAIT: begin
        HREADYOUT = 1'b0;
        RFIFO_REN = ~RFIFO_REMPTY;
      end
      S_RDATA: ;
      S_ERR1: begin
        HREADYOUT = 1'b0;
`ifdef MFP_AHB_SDRAM_ALIGN_ERR_EN
        HRESP     = 1'b1;
`endif
      end
      S_ERR2: begin
`ifdef MFP_AHB_SDRAM_ALIGN_ERR_EN
        HRESP     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Address phase is only accepted while HREADYOUT=1, i.e. idle or a final data-phase cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      if (w_capture && HREADYOUT) begin
        r_addr  <= HADDR;
        r_size  <= HSIZE;
        r_write <= HWRITE;
      end
      if (r_state == S_RDATA) r_hrdata <= RFIFO_RDATA[31:0];
    end
  end

  // Read FIFO is non-show-ahead: data popped in S_RWAIT is on RFIFO_RDATA during S_RDATA.
  assign HRDATA      = (r_state == S_RDATA) ? RFIFO_RDATA[31:0] : r_hrdata;
  assign CFIFO_WDATA = {r_write, r_size, r_addr & AddrMask};
  assign WFIFO_WDATA = {1'b0, HWDATA};

endmodule

// File: tb/tb_mfp_ahb_sdram_bridge.sv
// Directed self-checking bench for mfp_ahb_sdram_bridge; honours MFP_AHB_SDRAM_ALIGN_ERR_EN.
module tb_mfp_ahb_sdram_bridge;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP;
  logic        CFIFO_WEN, CFIFO_WFULL, WFIFO_WEN, WFIFO_WFULL, RFIFO_REN, RFIFO_REMPTY;
  logic [35:0] CFIFO_WDATA;
  logic [32:0] WFIFO_WDATA, RFIFO_RDATA;

  int n_tests = 0;
  int n_fail  = 0;

  mfp_ahb_sdram_bridge #(.ADDR_WIDTH(26)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA),
    .CFIFO_WFULL(CFIFO_WFULL), .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA),
    .WFIFO_WFULL(WFIFO_WFULL), .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA),
    .RFIFO_REMPTY(RFIFO_REMPTY)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; settle() moves to mid-cycle for sampling.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = s;
    HREADY = 1'b1;
  endtask

  task automatic bus_idle();
    HTRANS = 2'b00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cwen"}, {35'd0, CFIFO_WEN}, 36'd0);
    chk({tag, "_wwen"}, {35'd0, WFIFO_WEN}, 36'd0);
    chk({tag, "_ren"},  {35'd0, RFIFO_REN}, 36'd0);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b000;
    HTRANS = 2'b00; HREADY = 1'b1; HWDATA = '0;
    CFIFO_WFULL = 1'b0; WFIFO_WFULL = 1'b0; RFIFO_REMPTY = 1'b1; RFIFO_RDATA = '0;

    // Reset state
    step(); settle();
    chk("rst_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("rst_hresp",  {35'd0, HRESP}, 36'd0);
    chk("rst_hrdata", {4'd0, HRDATA}, 36'd0);
    chk("rst_cdata",  CFIFO_WDATA, 36'd0);
    chk_quiet("rst");
    step();
    HRESET = 1'b0;

    // 1: word write, FIFOs empty -> zero wait states. Command = {1, 010, 0x0000_1004}.
    addr_phase(32'h0000_1004, 1'b1, 3'b010);
    settle();
    chk("t1_idle_hready", {35'd0, HREADYOUT}, 36'd1);
    chk_quiet("t1_aphase");
    step();
    bus_idle();
    HWDATA = 32'hDEAD_BEEF;
    settle();
    chk("t1_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("t1_cwen",   {35'd0, CFIFO_WEN}, 36'd1);
    chk("t1_wwen",   {35'd0, WFIFO_WEN}, 36'd1);
    chk("t1_cdata",  CFIFO_WDATA, 36'hA_0000_1004);
    chk("t1_wdata",  {3'd0, WFIFO_WDATA}, 36'h0_DEAD_BEEF);
    step(); settle();
    chk_quiet("t1_after");

    // 2: write stalled by WFIFO_WFULL for 4 cycles.
    addr_phase(32'h0000_2008, 1'b1, 3'b010);
    WFIFO_WFULL = 1'b1;
    step();
    bus_idle();
    HWDATA = 32'h0000_55AA;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_stall%0d_hready", i), {35'd0, HREADYOUT}, 36'd0);
      chk_quiet($sformatf("t2_stall%0d", i));
      step();
    end
    WFIFO_WFULL = 1'b0;
    settle();
    chk("t2_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("t2_cwen",   {35'd0, CFIFO_WEN}, 36'd1);
    chk("t2_wwen",   {35'd0, WFIFO_WEN}, 36'd1);
    chk("t2_cdata",  CFIFO_WDATA, 36'hA_0000_2008);
    chk("t2_wdata",  {3'd0, WFIFO_WDATA}, 36'h0_0000_55AA);
    step(); settle();
    chk_quiet("t2_after");

    // 3: read, data arrives 5 cycles after the command push. Command = {0, 010, 0x2000}.
    addr_phase(32'h0000_2000, 1'b0, 3'b010);
    step();
    bus_idle();
    settle();
    chk("t3_rcmd_hready", {35'd0, HREADYOUT}, 36'd0);
    chk("t3_cwen",  {35'd0, CFIFO_WEN}, 36'd1);
    chk("t3_cdata", CFIFO_WDATA, 36'h2_0000_2000);
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t3_wait%0d_hready", i), {35'd0, HREADYOUT}, 36'd0);
      chk_quiet($sformatf("t3_wait%0d", i));
      step();
    end
    RFIFO_REMPTY = 1'b0;
    settle();
    chk("t3_ren", {35'd0, RFIFO_REN}, 36'd1);
    chk("t3_ren_cwen", {35'd0, CFIFO_WEN}, 36'd0);
    step();
    RFIFO_REMPTY = 1'b1;
    RFIFO_RDATA  = 33'h1_1234_5678;
    settle();
    chk("t3_hrdata", {4'd0, HRDATA}, 36'h0_1234_5678);
    chk("t3_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("t3_ren_once", {35'd0, RFIFO_REN}, 36'd0);
    step();
    RFIFO_RDATA = 33'h0_0BAD_0BAD;
    settle();
    chk("t3_hold", {4'd0, HRDATA}, 36'h0_1234_5678);
    chk_quiet("t3_after");

    // 4: write then pipelined read captured in the write's final cycle.
    addr_phase(32'h0000_3000, 1'b1, 3'b010);
    step();
    HWDATA = 32'hCAFE_F00D;
    addr_phase(32'h0000_4000, 1'b0, 3'b010);
    settle();
    chk("t4_w_cwen",  {35'd0, CFIFO_WEN}, 36'd1);
    chk("t4_w_cdata", CFIFO_WDATA, 36'hA_0000_3000);
    chk("t4_w_wdata", {3'd0, WFIFO_WDATA}, 36'h0_CAFE_F00D);
    step();
    bus_idle();
    settle();
    chk("t4_r_cwen",   {35'd0, CFIFO_WEN}, 36'd1);
    chk("t4_r_cdata",  CFIFO_WDATA, 36'h2_0000_4000);
    chk("t4_r_hready", {35'd0, HREADYOUT}, 36'd0);
    step();
    RFIFO_REMPTY = 1'b0;
    settle();
    chk("t4_ren", {35'd0, RFIFO_REN}, 36'd1);
    step();
    RFIFO_REMPTY = 1'b1;
    RFIFO_RDATA  = 33'h0_89AB_CDEF;
    settle();
    chk("t4_hrdata", {4'd0, HRDATA}, 36'h0_89AB_CDEF);
    step();

    // Halfword write with high address bits: bits [31:26] dropped. Command = {1, 001, 0x12}.
    addr_phase(32'hFC00_0012, 1'b1, 3'b001);
    step();
    bus_idle();
    HWDATA = 32'h0000_BEEF;
    settle();
    chk("t4b_cdata", CFIFO_WDATA, 36'h9_0000_0012);
    chk("t4b_cwen",  {35'd0, CFIFO_WEN}, 36'd1);
    step();

    // 5: reset while waiting for read data.
    addr_phase(32'h0000_5000, 1'b0, 3'b010);
    step();
    bus_idle();
    step(); settle();
    chk("t5_rwait_hready", {35'd0, HREADYOUT}, 36'd0);
    HRESET = 1'b1;
    #1;
    chk("t5_rst_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("t5_rst_hresp",  {35'd0, HRESP}, 36'd0);
    chk("t5_rst_hrdata", {4'd0, HRDATA}, 36'd0);
    chk_quiet("t5_rst");
    RFIFO_REMPTY = 1'b0;
    step(); step();
    HRESET = 1'b0;
    settle();
    chk_quiet("t5_idle0");
    step(); settle();
    chk_quiet("t5_idle1");
    chk("t5_idle_hready", {35'd0, HREADYOUT}, 36'd1);
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1;
    step(); settle();
    chk_quiet("t5_unsel");
    chk("t5_unsel_hready", {35'd0, HREADYOUT}, 36'd1);
    RFIFO_REMPTY = 1'b1;
    bus_idle();
    step();

    // 6: misaligned word write to 0x0000_0002.
    addr_phase(32'h0000_0002, 1'b1, 3'b010);
    step();
    bus_idle();
    HWDATA = 32'h0000_0077;
    settle();
`ifdef MFP_AHB_SDRAM_ALIGN_ERR_EN
    chk("t6_err1_hready", {35'd0, HREADYOUT}, 36'd0);
    chk("t6_err1_hresp",  {35'd0, HRESP}, 36'd1);
    chk_quiet("t6_err1");
    step(); settle();
    chk("t6_err2_hready", {35'd0, HREADYOUT}, 36'd1);
    chk("t6_err2_hresp",  {35'd0, HRESP}, 36'd1);
    chk_quiet("t6_err2");
    step(); settle();
    chk("t6_done_hresp", {35'd0, HRESP}, 36'd0);
    chk_quiet("t6_done");
`else
    chk("t6_cwen",  {35'd0, CFIFO_WEN}, 36'd1);
    chk("t6_cdata", CFIFO_WDATA, 36'hA_0000_0002);
    chk("t6_hresp", {35'd0, HRESP}, 36'd0);
    chk("t6_hready", {35'd0, HREADYOUT}, 36'd1);
    step(); settle();
    chk_quiet("t6_done");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
